// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module  : stream_demux_pkg
// Brief   : Shared types and helpers for the stream_demux 1-to-N distributor.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  // Width of the optional saturating drop counter.
  localparam int DROP_CNT_W = 16;

  // Select width needed to address n channels.
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

  // Occupancy of a one-entry channel holding register.
  typedef enum logic [0:0] {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/stream_demux_if.sv
// ============================================================================
// Module  : stream_demux_if
// Brief   : Producer-side input stream plus the N consumer-side channels of
//           stream_demux. "master" is the environment, "slave" the demux.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 8
);
  localparam int SEL_W = sel_width(N);

  logic               in_valid;
  logic [W-1:0]       in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_ready;
  logic [N-1:0]       out_valid;
  logic [N*W-1:0]     out_data;
  logic [N-1:0]       out_ready;
  logic               sel_err;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

endinterface

`default_nettype wire

// File: rtl/stream_demux_chan_reg.sv
// ============================================================================
// Module  : demux_chan_reg
// Brief   : One-entry holding register for a single demux output channel.
//           A write always wins over a drain, so a simultaneous drain and
//           write keeps the register full with the newer beat.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module demux_chan_reg
  import stream_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_wr_en,
  input  wire logic [W-1:0] i_wr_data,
  input  wire logic         i_rd_ready,
  output logic              o_valid,
  output logic [W-1:0]      o_data
);

  ch_state_t    r_state;
  logic [W-1:0] r_data;

  // Occupancy state machine and payload capture; data holds when not written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        CH_EMPTY: begin
          if (i_wr_en) begin
            r_state <= CH_FULL;
            r_data  <= i_wr_data;
          end
        end
        CH_FULL: begin
          if (i_wr_en) begin
            r_data  <= i_wr_data;
          end else if (i_rd_ready) begin
            r_state <= CH_EMPTY;
          end
        end
        default: r_state <= CH_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == CH_FULL);
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// Module  : stream_demux
// Brief   : Sequential 1-to-N stream demultiplexer with valid/ready on every
//           side. Each accepted beat lands in a one-entry register on the
//           selected channel; out-of-range selects are swallowed and flagged
//           with a one-cycle sel_err pulse.
// Options : STREAM_DEMUX_DROP_CNT_EN adds drop_cnt, a saturating count of
//           discarded out-of-range beats.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N = 7,
  parameter int W = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  stream_demux_if.slave bus
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int SEL_W = sel_width(N);

  logic [N-1:0]   w_sel_hit;
  logic [N-1:0]   w_wr_en;
  logic [N-1:0]   w_out_valid;
  logic [N*W-1:0] w_out_data;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_drop;
  logic           r_sel_err;

  // One-hot select decode; an out-of-range index matches no channel.
  always_comb begin
    w_sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      w_sel_hit[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  // Ready follows the addressed channel; unmatched selects are always taken.
  always_comb begin
    w_in_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (w_sel_hit[k]) begin
        w_in_ready = ~w_out_valid[k] | bus.out_ready[k];
      end
    end
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_wr_en  = {N{w_accept}} & w_sel_hit;
  assign w_drop   = w_accept & ~(|w_sel_hit);

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_reg #(
      .W (W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_wr_en[k]),
      .i_wr_data  (bus.in_data),
      .i_rd_ready (bus.out_ready[k]),
      .o_valid    (w_out_valid[k]),
      .o_data     (w_out_data[k*W +: W])
    );
  end

  // Flag a discarded out-of-range beat for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_drop;
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Count discarded beats, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.sel_err   = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// Module  : tb_stream_demux
// Brief   : Self-checking bench for stream_demux (N=7, W=8). A vector table
//           covers routing, drain+write and out-of-range beats; hand-written
//           sequences cover back-pressure, reset and the drop counter. A
//           per-channel queue scoreboard checks delivery order and uniqueness.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int N     = 7;
  localparam int W     = 8;
  localparam int SEL_W = sel_width(N);
  localparam int NVEC  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stream_demux_if #(.N(N), .W(W)) bus ();

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
  stream_demux #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );
`else
  stream_demux #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] sb_q [N][$];
  logic         sb_exp_err = 1'b0;
  logic [N-1:0] sb_exp_v;
  logic [W-1:0] sb_exp_d;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < N; k++) sb_q[k].delete();
        sb_exp_err = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) sb_exp_v[k] = (sb_q[k].size() != 0);
        check("sb out_valid", bus.out_valid, sb_exp_v);
        check("sb sel_err", bus.sel_err, sb_exp_err);
        for (int k = 0; k < N; k++) begin
          if (bus.out_valid[k] && bus.out_ready[k]) begin
            if (sb_q[k].size() == 0) begin
              check($sformatf("sb ch%0d unexpected beat", k), 64'(bus.out_valid[k]), 64'd0);
            end else begin
              sb_exp_d = sb_q[k].pop_front();
              check($sformatf("sb ch%0d data", k), bus.out_data[k*W +: W], sb_exp_d);
            end
          end
        end
        sb_exp_err = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
          if (bus.in_sel < SEL_W'(N)) sb_q[bus.in_sel].push_back(bus.in_data);
          else sb_exp_err = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [SEL_W-1:0] s,
                       input logic [W-1:0] d, input logic [N-1:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  // Drive just after a rising edge, then move to the sampling point.
  task automatic step(input logic v, input logic [SEL_W-1:0] s,
                      input logic [W-1:0] d, input logic [N-1:0] r);
    @(posedge clk);
    #1;
    drive(v, s, d, r);
    @(negedge clk);
  endtask

  typedef struct {
    logic             v;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     d;
    logic [N-1:0]     ordy;
    logic             rdy;
    logic [N-1:0]     ov;
    logic             err;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // v, sel, data, out_ready | in_ready, out_valid, sel_err (state seen this cycle)
    vecs[0]  = '{1'b1, 3'd3, 8'hA5, 7'h7F, 1'b1, 7'h00, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h08, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h00, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 8'h01, 7'h7E, 1'b1, 7'h00, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 8'h02, 7'h7F, 1'b1, 7'h01, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 7'h7E, 1'b0, 7'h01, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h01, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 8'hFF, 7'h7F, 1'b1, 7'h00, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h00, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h00, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 8'h44, 7'h7B, 1'b1, 7'h00, 1'b0};
    vecs[11] = '{1'b1, 3'd7, 8'hEE, 7'h7B, 1'b1, 7'h04, 1'b0};
    vecs[12] = '{1'b1, 3'd6, 8'h66, 7'h7B, 1'b1, 7'h04, 1'b1};
    vecs[13] = '{1'b0, 3'd2, 8'h00, 7'h7B, 1'b0, 7'h44, 1'b0};
    vecs[14] = '{1'b0, 3'd2, 8'h00, 7'h7F, 1'b1, 7'h04, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 8'h00, 7'h7F, 1'b1, 7'h00, 1'b0};

    // 1. Reset with a valid beat presented the whole time.
    drive(1'b1, 3'd3, 8'h5A, 7'h7F);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", bus.out_valid, 7'h00);
    check("reset out_data", bus.out_data, 56'h0);
    check("reset sel_err", bus.sel_err, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 8'h00, 7'h7F);
    rst_n = 1'b1;
    step(1'b0, 3'd0, 8'h00, 7'h7F);
    check("post-reset out_valid", bus.out_valid, 7'h00);
    check("post-reset out_data", bus.out_data, 56'h0);

    // 2/4/5. Table of routing, drain+write and out-of-range vectors.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].rdy);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].ov);
      check($sformatf("vec%0d sel_err", i), bus.sel_err, vecs[i].err);
    end
    check("ch3 retained data", bus.out_data[31:24], 8'hA5);
    check("ch0 retained data", bus.out_data[7:0], 8'h02);

`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_cnt after table", drop_cnt, 16'd2);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 3'd7, 8'hFF, 7'h7F);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 8'h00, 7'h7F);
    @(negedge clk);
    check("drop_cnt saturated", drop_cnt, 16'hFFFF);
`endif

    // 3. Back-pressure on channel 2 while channel 5 keeps flowing.
    step(1'b1, 3'd2, 8'h11, 7'h7B);
    check("bp first beat ready", bus.in_ready, 1'b1);
    step(1'b1, 3'd2, 8'h22, 7'h7B);
    check("bp second beat stalled", bus.in_ready, 1'b0);
    step(1'b1, 3'd2, 8'h22, 7'h7B);
    check("bp still stalled", bus.in_ready, 1'b0);
    step(1'b0, 3'd2, 8'h00, 7'h7B);
    step(1'b1, 3'd5, 8'h33, 7'h7B);
    check("bp other channel ready", bus.in_ready, 1'b1);
    check("bp ch2 held", bus.out_valid, 7'h04);
    step(1'b1, 3'd2, 8'h22, 7'h7F);
    check("bp drain+write ready", bus.in_ready, 1'b1);
    check("bp ch2 and ch5 full", bus.out_valid, 7'h24);
    check("bp ch5 data", bus.out_data[47:40], 8'h33);
    step(1'b0, 3'd0, 8'h00, 7'h7F);
    check("bp second beat held", bus.out_valid, 7'h04);
    check("bp second beat data", bus.out_data[23:16], 8'h22);
    step(1'b0, 3'd0, 8'h00, 7'h7F);
    check("bp all drained", bus.out_valid, 7'h00);

    // 6. Asynchronous reset while channels 1 and 4 hold beats.
    step(1'b1, 3'd1, 8'hA1, 7'h00);
    step(1'b1, 3'd4, 8'hB4, 7'h00);
    step(1'b0, 3'd0, 8'h00, 7'h00);
    check("mid ch1/ch4 full", bus.out_valid, 7'h12);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", bus.out_valid, 7'h00);
    check("async reset out_data", bus.out_data, 56'h0);
    check("async reset sel_err", bus.sel_err, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 8'h00, 7'h7F);
      check($sformatf("after reset idle%0d", i), bus.out_valid, 7'h00);
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_cnt reset", drop_cnt, 16'd0);
`endif

    for (int k = 0; k < N; k++) begin
      check($sformatf("sb ch%0d leftover", k), 64'(sb_q[k].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
